// File: rtl/ser_pkg.sv
// Shared definitions for the shift_serializer transmit path.
// State encoding, counter sizing and output reset values.
package ser_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SHIFT  = 2'b01;
    localparam logic [1:0] ST_PARITY = 2'b10;

    localparam logic SDATA_RST  = 1'b0;
    localparam logic SFRAME_RST = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register; tap is the bit currently on the wire.
// Direction selected by MSB_FIRST, vacated end filled from fill.
module piso_shift_reg
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    output logic             tap
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {WIDTH{SDATA_RST}};
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            if (MSB_FIRST != 0) sr <= {sr[WIDTH-2:0], fill};
            else                sr <= {fill, sr[WIDTH-1:1]};
        end
    end

    assign tap = (MSB_FIRST != 0) ? sr[WIDTH-1] : sr[0];

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out transmitter with framing strobe and done pulse.
// Define SER_PARITY_EN to append an even-parity bit to every frame.
module shift_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             done
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    cnt;
    logic             final_c;
    logic             accept;
    logic             sr_load;
    logic             sr_shift;
    logic             fill;
    logic [WIDTH-1:0] sr_data;

`ifdef SER_PARITY_EN
    logic par;

    // Parity is shifted in behind the data so it reaches the tap last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         par <= 1'b0;
        else if (accept) par <= ^data_in;
    end

    assign final_c = (state == ST_PARITY);
    assign fill    = par;
`else
    assign final_c = (state == ST_SHIFT) && (cnt == LAST);
    assign fill    = 1'b0;
`endif

    assign load_ready = (state == ST_IDLE) || final_c;
    assign done       = final_c;
    assign accept     = load_valid & load_ready;

    always_comb begin
        state_nxt = state;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_data   = data_in;
        if (accept) begin
            state_nxt = ST_SHIFT;
            sr_load   = 1'b1;
        end else if (final_c) begin
            // Clearing on frame end keeps sdata low while idle.
            state_nxt = ST_IDLE;
            sr_load   = 1'b1;
            sr_data   = '0;
        end else if (state == ST_SHIFT) begin
            sr_shift  = 1'b1;
            state_nxt = (cnt == LAST) ? ST_PARITY : ST_SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sframe <= SFRAME_RST;
        end else begin
            state  <= state_nxt;
            cnt    <= (sr_shift && cnt != LAST) ? cnt + 1'b1 : '0;
            sframe <= (state_nxt != ST_IDLE);
        end
    end

    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sr (
        .clk  (clk),
        .rst  (rst),
        .load (sr_load),
        .shift(sr_shift),
        .data (sr_data),
        .fill (fill),
        .tap  (sdata)
    );

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus,
// each cycle compared against a frame-queue reference model.
module tb_shift_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;

    logic ready_m, sdata_m, sframe_m, done_m;
    logic ready_l, sdata_l, sframe_l, done_l;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] w;
        int         idx;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    bit   cur_v = 1'b0;
    bit   acc   = 1'b0;

    always #5 clk = ~clk;

    shift_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(ready_m), .sdata(sdata_m), .sframe(sframe_m), .done(done_m)
    );

    shift_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(ready_l), .sdata(sdata_l), .sframe(sframe_l), .done(done_l)
    );

    // Expected {frame, bit, done, ready} for MSB instance then LSB instance.
    function automatic logic [7:0] exp_vec();
        logic f, m, l, d, r;
        f = cur_v;
        d = cur_v && (cur.idx == FL - 1);
        r = !cur_v || d;
        m = 1'b0;
        l = 1'b0;
        if (cur_v) begin
            if (cur.idx == W) begin
                m = ^cur.w;
                l = m;
            end else begin
                m = cur.w[W-1-cur.idx];
                l = cur.w[cur.idx];
            end
        end
        return {f, m, d, r, f, l, d, r};
    endfunction

    function automatic logic [7:0] act_vec();
        return {sframe_m, sdata_m, done_m, ready_m,
                sframe_l, sdata_l, done_l, ready_l};
    endfunction

    // One clock edge: the model accepts, queues the frame, advances a bit.
    task automatic tick();
        bit ready_now;
        logic [7:0] w;
        ready_now = !cur_v || (cur.idx == FL - 1);
        acc = load_valid && ready_now && !rst;
        w = data_in;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cur_v = 1'b0;
            acc = 1'b0;
        end else begin
            if (acc)
                for (int i = 0; i < FL; i++) q.push_back('{w: w, idx: i});
            if (q.size() > 0) begin
                cur = q.pop_front();
                cur_v = 1'b1;
            end else begin
                cur_v = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (act_vec() !== 8'h11) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", act_vec(), 8'h11);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", act_vec(), exp_vec());
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] got;
        int nf;
        got = '0;
        nf = 0;
        data_in = 8'hA5;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= FL + 2; c++) begin
            data_in = 8'($urandom);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL msb_a5 cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
            if (c <= W) got = {got[6:0], sdata_m};
            nf += int'(sframe_m);
            tick();
        end
        checks++;
        if (got !== 8'hA5) begin
            errors++;
            $display("FAIL msb_a5_word: got %h want %h", got, 8'hA5);
        end
        checks++;
        if (nf != FL) begin
            errors++;
            $display("FAIL msb_a5_frame_len: got %0d want %0d", nf, FL);
        end
    endtask

    task automatic test_lsb_hold();
        logic [7:0] got;
        got = '0;
        data_in = 8'h01;
        load_valid = 1'b1;
        tick();
        for (int c = 1; c <= FL; c++) begin
            data_in = 8'($urandom);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lsb_hold cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
            if (c <= W) got = {sdata_l, got[7:1]};
            tick();
        end
        load_valid = 1'b0;
        checks++;
        if (got !== 8'h01) begin
            errors++;
            $display("FAIL lsb_word: got %h want %h", got, 8'h01);
        end
        for (int c = 0; c < FL + 2; c++) begin
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL lsb_drain cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int nf;
        int nd;
        int done_at[$];
        nf = 0;
        nd = 0;
        data_in = 8'hFF;
        load_valid = 1'b1;
        tick();
        data_in = 8'h00;
        for (int c = 1; c <= 2 * FL + 1; c++) begin
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
            nf += int'(sframe_m);
            if (done_m) done_at.push_back(c);
            tick();
            if (acc) load_valid = 1'b0;
        end
        checks++;
        if (nf != 2 * FL) begin
            errors++;
            $display("FAIL b2b_frame_len: got %0d want %0d", nf, 2 * FL);
        end
        nd = done_at.size();
        checks++;
        if (nd != 2 || done_at[0] != FL || done_at[1] != 2 * FL) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses want 2 at %0d,%0d",
                     nd, FL, 2 * FL);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        got = '0;
        data_in = 8'hC3;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (act_vec() !== 8'h11) begin
            errors++;
            $display("FAIL rst_mid_async: got %b want %b", act_vec(), 8'h11);
        end
        tick();
        checks++;
        if (act_vec() !== 8'h11) begin
            errors++;
            $display("FAIL rst_mid_held: got %b want %b", act_vec(), 8'h11);
        end
        rst = 1'b0;
        data_in = 8'h3C;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= FL + 1; c++) begin
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_next cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
            if (c <= W) got = {got[6:0], sdata_m};
            tick();
        end
        checks++;
        if (got !== 8'h3C) begin
            errors++;
            $display("FAIL rst_mid_word: got %h want %h", got, 8'h3C);
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic       pbit [2];
        words[0] = 8'h07;
        words[1] = 8'h03;
        pbit[0] = 1'b1;
        pbit[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            data_in = words[k];
            load_valid = 1'b1;
            tick();
            load_valid = 1'b0;
            for (int c = 1; c <= FL; c++) begin
                checks++;
                if (act_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL parity_%h cyc %0d: got %b want %b",
                             words[k], c, act_vec(), exp_vec());
                end
                if (c == FL) begin
                    checks++;
                    if ({sframe_m, sdata_m, done_m} !== {2'b11, 1'b1} ^
                        {1'b0, ~pbit[k], 1'b0}) begin
                        errors++;
                        $display("FAIL parity_bit_%h: got %b want %b",
                                 words[k], {sframe_m, sdata_m, done_m},
                                 {1'b1, pbit[k], 1'b1});
                    end
                end
                tick();
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load_valid = ($urandom_range(3) != 0);
            data_in = 8'($urandom);
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
        end
        load_valid = 1'b0;
        for (int c = 0; c < FL + 2; c++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_drain cyc %0d: got %b want %b",
                         c, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_hold();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_serializer.md
Name: shift_serializer

Overview:
Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk on sdata, with a framing strobe. It is the transmit end of the team's serial link; the DFF-chain deserializer on the far side samples sdata while sframe is high. It sits between the datapath word register and the serial pad.

Parameters:
WIDTH, 8, data word width in bits (>=2)
MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 first

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  WIDTH  word to transmit; sampled only on accept
load_valid  input  1  producer has a word on data_in
load_ready  output  1  serializer can accept a word this cycle
sdata  output  1  serial data bit, registered
sframe  output  1  high while sdata carries a valid bit, registered
done  output  1  one-cycle pulse coincident with the last transmitted bit

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1: state=IDLE, shift register=0, bit counter=0, sdata=0, sframe=0, done=0, load_ready=1.
- Accept: a transfer occurs on a rising edge where load_valid & load_ready. data_in is captured on that edge only. A change to data_in after accept has no effect.
- States:
  - IDLE: load_ready=1, sframe=0, sdata=0. On accept -> SHIFT.
  - SHIFT: one bit per cycle. The first bit appears on sdata in the cycle after the accepting edge, so latency is 1 cycle. Bit order follows MSB_FIRST. The counter counts 0..WIDTH-1. Counter width is clog2(WIDTH).
- Last bit: the cycle with counter=WIDTH-1 (or the PARITY cycle when that feature is enabled) is the final cycle.
  - done=1 and load_ready=1 in that cycle only.
  - If accept occurs on the final edge, the next word's first bit follows immediately. There is no gap, and sframe stays high.
  - Otherwise the next state is IDLE.
- load_ready is 0 in every non-final SHIFT cycle. load_valid is ignored there and the data is not captured.
- load_ready is combinational from state only, with no path from load_valid.
- A single-word transfer gives exactly WIDTH sframe cycles (WIDTH+1 with parity).
- Reset mid-frame: the frame is abandoned and outputs drop to reset values immediately (asynchronously). No partial done pulse is issued. The next accept after rst deasserts starts a clean frame.
- Simultaneous load_valid and rst: rst wins and nothing is captured.

Optional Feature:
Macro SER_PARITY_EN.
- Defined: an extra PARITY state follows the last data bit. It drives sdata = XOR of all captured data bits, i.e. an even-parity bit, with sframe=1. done and load_ready move to the PARITY cycle.
- Undefined: there is no PARITY state, the frame is exactly WIDTH bits, and the parity logic is absent.

Decomposition:
- Package ser_pkg holds:
  - the state encoding (IDLE, SHIFT, PARITY);
  - a clog2 constant function used for counter width;
  - the reset-value constants for sdata and sframe.
- One sub-module, piso_shift_reg. It is a WIDTH-bit parallel-load shift register with an async active-high reset, a load enable, a shift enable and a direction chosen by MSB_FIRST.
- The FSM and counter remain in shift_serializer.

Test Plan:
1. Reset: assert rst mid-clock with no edge -> sdata=0, sframe=0, done=0, load_ready=1 immediately.
2. WIDTH=8, MSB_FIRST=1, accept 8'hA5 -> sdata 1,0,1,0,0,1,0,1 on cycles 1..8 after accept; sframe high for exactly 8 cycles; done only on cycle 8.
3. MSB_FIRST=0, accept 8'h01 -> sdata 1,0,0,0,0,0,0,0; load_valid held during SHIFT is not accepted until cycle 8.
4. Back-to-back: load_valid held high with 8'hFF then 8'h00 -> 16 contiguous sframe cycles, eight 1s then eight 0s; load_ready high only in the final-bit cycles; done at cycles 8 and 16.
5. Reset mid-frame: accept 8'hC3, assert rst during bit 4 -> outputs zero asynchronously with no done pulse; after release, accept 8'h3C -> correct clean frame.
6. SER_PARITY_EN defined, accept 8'h07 -> 9 sframe cycles, ninth bit = 1; with 8'h03 the ninth bit = 0; done on cycle 9.
